lifo_stack: RTL and testbench

Parametrised last-in-first-out storage; the next generation of the single-bit enabled D flip-flop in Memory_Structures, generalised to DEPTH words of WIDTH bits. Push and pop are synchronous, and the popped word is presented on a registered output. A global enable Re freezes all state, and the active-low asynchronous init inz clears the stack. Used as a return-address or operand stack by later datapath exercises.

---
 rtl/lifo_stack_pkg.sv | 17 +
 rtl/lifo_stack_if.sv | 38 +++
 rtl/lifo_stack_mem.sv | 29 ++
 rtl/lifo_stack.sv | 131 +++++++++++++
 tb/tb_lifo_stack.sv | 161 ++++++++++++++++
 5 files changed

// File: rtl/lifo_stack_pkg.sv
// lifo_pkg: shared types and helpers for the lifo_stack slice.
//   cnt_w(depth) : width of a counter that holds 0..depth inclusive
//   op_e         : stack operation decoded from {push, pop}
package lifo_pkg;

  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_SWAP = 2'b11
  } op_e;

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/lifo_stack_if.sv
// lifo_stack_if: control/data bundle between a stack user and lifo_stack.
//   Re, push, pop, D    : user -> stack (enable, operation, push data)
//   clr_err             : user -> stack, only when LIFO_ERR_FLAGS_EN is defined
//   Q, count            : stack -> user (last popped word, occupancy)
//   empty, full         : stack -> user (occupancy decode)
//   ovf, udf            : stack -> user (sticky error flags)
// Modports: master = stack user, slave = lifo_stack.
interface lifo_stack_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int CW = lifo_pkg::cnt_w(DEPTH);

  logic             Re;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] D;
  logic [WIDTH-1:0] Q;
  logic [CW-1:0]    count;
  logic             empty;
  logic             full;
  logic             ovf;
  logic             udf;
`ifdef LIFO_ERR_FLAGS_EN
  logic             clr_err;

  modport master (output Re, push, pop, D, clr_err,
                  input  Q, count, empty, full, ovf, udf);
  modport slave  (input  Re, push, pop, D, clr_err,
                  output Q, count, empty, full, ovf, udf);
`else
  modport master (output Re, push, pop, D,
                  input  Q, count, empty, full, ovf, udf);
  modport slave  (input  Re, push, pop, D,
                  output Q, count, empty, full, ovf, udf);
`endif

endinterface

// File: rtl/lifo_stack_mem.sv
// lifo_mem: DEPTH x WIDTH register array, no reset on contents.
//   clk   : write clock
//   we    : write enable, writes wdata to mem[waddr] on the rising edge
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : combinational read of mem[raddr] (returns pre-edge contents)
module lifo_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/lifo_stack.sv
// lifo_stack: parametrised LIFO with registered pop output.
//   clk  : rising-edge clock
//   inz  : asynchronous active-low init (clears count, Q and flags)
//   bus  : lifo_stack_if.slave (Re, push, pop, D in; Q, count, empty,
//          full, ovf, udf out; clr_err in when enabled)
// Optional feature: define LIFO_ERR_FLAGS_EN for sticky ovf/udf flags with
// a synchronous clr_err; otherwise ovf/udf are tied low.
module lifo_stack
  import lifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int CW   = cnt_w(DEPTH),
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic      clk,
  input  logic      inz,
  lifo_stack_if.slave bus
);

  op_e              op;
  logic [CW-1:0]    count_p1;
  logic [CW-1:0]    count_nxt;
  logic [WIDTH-1:0] q_p1;
  logic [WIDTH-1:0] rdata;
  logic [AW-1:0]    top_addr;
  logic [AW-1:0]    waddr;
  logic             we;
  logic             q_ld;
  logic             empty;
  logic             full;

  assign op    = op_e'({bus.push, bus.pop});
  assign empty = (count_p1 == '0);
  assign full  = (count_p1 == CW'(DEPTH));

  // Top-of-stack address; guarded so an empty stack never indexes past DEPTH.
  assign top_addr = empty ? '0 : AW'(count_p1 - CW'(1));

  always_comb begin
    count_nxt = count_p1;
    we        = 1'b0;
    waddr     = '0;
    q_ld      = 1'b0;
    if (bus.Re) begin
      case (op)
        OP_PUSH: begin
          if (!full) begin
            we        = 1'b1;
            waddr     = AW'(count_p1);
            count_nxt = count_p1 + CW'(1);
          end
        end
        OP_POP: begin
          if (!empty) begin
            q_ld      = 1'b1;
            count_nxt = count_p1 - CW'(1);
          end
        end
        OP_SWAP: begin
          // Replace the top: Q takes the old top while D overwrites it.
          // On an empty stack the pop half is dropped and D becomes word 0.
          we = 1'b1;
          if (!empty) begin
            q_ld  = 1'b1;
            waddr = top_addr;
          end else begin
            count_nxt = CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  lifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (bus.D),
    .raddr (top_addr),
    .rdata (rdata)
  );

  // Pop stage: occupancy and popped word registered together.
  always_ff @(posedge clk or negedge inz) begin
    if (!inz) begin
      count_p1 <= '0;
      q_p1     <= '0;
    end else begin
      count_p1 <= count_nxt;
      if (q_ld) q_p1 <= rdata;
    end
  end

`ifdef LIFO_ERR_FLAGS_EN
  logic ovf_p1;
  logic udf_p1;
  logic ovf_set;
  logic udf_set;

  assign ovf_set = bus.Re && (op == OP_PUSH) && full;
  assign udf_set = bus.Re && ((op == OP_POP) || (op == OP_SWAP)) && empty;

  // A set event in the same cycle as clr_err keeps the flag high.
  always_ff @(posedge clk or negedge inz) begin
    if (!inz) begin
      ovf_p1 <= 1'b0;
      udf_p1 <= 1'b0;
    end else if (bus.Re) begin
      ovf_p1 <= ovf_set | (ovf_p1 & ~bus.clr_err);
      udf_p1 <= udf_set | (udf_p1 & ~bus.clr_err);
    end
  end

  assign bus.ovf = ovf_p1;
  assign bus.udf = udf_p1;
`else
  assign bus.ovf = 1'b0;
  assign bus.udf = 1'b0;
`endif

  assign bus.Q     = q_p1;
  assign bus.count = count_p1;
  assign bus.empty = empty;
  assign bus.full  = full;

endmodule

// File: tb/tb_lifo_stack.sv
// tb_lifo_stack: directed-vector bench for lifo_stack (WIDTH=8, DEPTH=4).
// Stimulus queues the hand-computed post-edge state; a monitor pops and
// compares at each falling edge, or immediately for asynchronous checks.
// Builds with or without LIFO_ERR_FLAGS_EN.
module tb_lifo_stack;

`ifdef LIFO_ERR_FLAGS_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif

  typedef struct {
    string      name;
    int         cnt;
    logic [7:0] q;
    bit         ovf;
    bit         udf;
  } exp_t;

  logic clk;
  logic inz;
  exp_t sb[$];
  event chk_now;
  int   n_chk  = 0;
  int   n_pass = 0;

  lifo_stack_if #(.WIDTH(8), .DEPTH(4)) bus ();

  lifo_stack #(.WIDTH(8), .DEPTH(4)) dut (
    .clk (clk),
    .inz (inz),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Monitor: compares every queued expectation against the DUT outputs.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk or chk_now);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        chk({e.name, ".count"}, 32'(bus.count), 32'(e.cnt));
        chk({e.name, ".Q"},     32'(bus.Q),     32'(e.q));
        chk({e.name, ".empty"}, 32'(bus.empty), 32'(e.cnt == 0));
        chk({e.name, ".full"},  32'(bus.full),  32'(e.cnt == 4));
        chk({e.name, ".ovf"},   32'(bus.ovf),   32'(FLAGS & e.ovf));
        chk({e.name, ".udf"},   32'(bus.udf),   32'(FLAGS & e.udf));
      end
    end
  end

  // One clocked operation; expectation describes the state after the edge.
  task automatic step(input bit re, input bit ps, input bit pp, input logic [7:0] d,
                      input bit clr, input string nm, input int c, input logic [7:0] q,
                      input bit o, input bit u);
    @(negedge clk);
    bus.Re   = re;
    bus.push = ps;
    bus.pop  = pp;
    bus.D    = d;
`ifdef LIFO_ERR_FLAGS_EN
    bus.clr_err = clr;
`else
    if (clr) bus.D = d;
`endif
    @(posedge clk);
    #1;
    bus.Re   = 1'b1;
    bus.push = 1'b0;
    bus.pop  = 1'b0;
`ifdef LIFO_ERR_FLAGS_EN
    bus.clr_err = 1'b0;
`endif
    sb.push_back('{nm, c, q, o, u});
  endtask

  // Assert inz between edges and check the cleared state before any edge.
  task automatic async_reset(input string nm);
    @(negedge clk);
    #1 inz = 1'b0;
    #1 sb.push_back('{nm, 0, 8'h00, 1'b0, 1'b0});
    ->chk_now;
    #1 inz = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_chk);
    $fatal(1, "watchdog expired");
  end

  initial begin
    inz      = 1'b0;
    bus.Re   = 1'b0;
    bus.push = 1'b0;
    bus.pop  = 1'b0;
    bus.D    = 8'h00;
`ifdef LIFO_ERR_FLAGS_EN
    bus.clr_err = 1'b0;
`endif
    #3 sb.push_back('{"init_reset", 0, 8'h00, 1'b0, 1'b0});
    ->chk_now;
    @(negedge clk);
    inz    = 1'b1;
    bus.Re = 1'b1;

    //   re push pop D      clr name          cnt Q      ovf  udf
    step(1, 1, 0, 8'h11, 0, "pre_push11", 1, 8'h00, 0, 0);
    step(1, 1, 0, 8'h22, 0, "pre_push22", 2, 8'h00, 0, 0);
    step(1, 1, 0, 8'h33, 0, "pre_push33", 3, 8'h00, 0, 0);
    step(1, 0, 1, 8'h00, 0, "pre_pop",    2, 8'h33, 0, 0);
    async_reset("mid_reset");

    step(1, 1, 0, 8'h11, 0, "fill11",   1, 8'h00, 0, 0);
    step(1, 1, 0, 8'h22, 0, "fill22",   2, 8'h00, 0, 0);
    step(1, 1, 0, 8'h33, 0, "fill33",   3, 8'h00, 0, 0);
    step(1, 1, 0, 8'h44, 0, "fill44",   4, 8'h00, 0, 0);
    step(1, 1, 0, 8'h55, 0, "push_ovf", 4, 8'h00, 1, 0);
    step(1, 0, 1, 8'h00, 0, "pop44",    3, 8'h44, 1, 0);
    step(1, 0, 1, 8'h00, 0, "pop33",    2, 8'h33, 1, 0);
    step(1, 0, 1, 8'h00, 0, "pop22",    1, 8'h22, 1, 0);
    step(1, 0, 1, 8'h00, 0, "pop11",    0, 8'h11, 1, 0);

    step(1, 0, 1, 8'h00, 0, "pop_udf",      0, 8'h11, 1, 1);
    step(1, 0, 0, 8'h00, 1, "clr_err",      0, 8'h11, 0, 0);
    step(1, 0, 1, 8'h00, 1, "udf_beats_clr",0, 8'h11, 0, 1);
    step(1, 0, 0, 8'h00, 1, "clr_again",    0, 8'h11, 0, 0);

    step(1, 1, 0, 8'hA1, 0, "pushA1",   1, 8'h11, 0, 0);
    step(1, 1, 0, 8'hB2, 0, "pushB2",   2, 8'h11, 0, 0);
    step(1, 1, 1, 8'hC3, 0, "swapC3",   2, 8'hB2, 0, 0);
    step(1, 0, 1, 8'h00, 0, "popC3",    1, 8'hC3, 0, 0);

    step(1, 1, 0, 8'h77, 0, "push77",   2, 8'hC3, 0, 0);
    step(0, 1, 1, 8'hFF, 0, "hold1",    2, 8'hC3, 0, 0);
    step(0, 1, 1, 8'hFF, 0, "hold2",    2, 8'hC3, 0, 0);
    step(0, 1, 1, 8'hFF, 0, "hold3",    2, 8'hC3, 0, 0);
    step(1, 0, 1, 8'h00, 0, "pop77",    1, 8'h77, 0, 0);
    step(1, 0, 1, 8'h00, 0, "popA1",    0, 8'hA1, 0, 0);

    step(1, 1, 1, 8'h5A, 0, "empty_swap", 1, 8'hA1, 0, 1);
    step(1, 0, 1, 8'h00, 0, "pop5A",      0, 8'h5A, 0, 1);

    @(negedge clk);
    #1;
    chk("scoreboard_drain", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
